fir_tap_accumulator: RTL and testbench

- Downstream neighbour of the 16x3 saturating tap multiplier in the FIR datapath.
- Consumes one registered 16-bit signed product per valid cycle, tagged with its 4-bit tap index.
- Sums NUM_TAPS products into a wide accumulator and emits one saturated 16-bit FIR output sample per completed frame, with a one-cycle valid strobe.
- Detects tap-sequence violations and raises a sticky error flag.

---
 rtl/fir_tap_accumulator_if.sv | 22 ++
 rtl/fir_tap_accumulator.sv | 89 ++++++++
 tb/tb_fir_tap_accumulator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_accumulator_if.sv
// Product/tap-index handshake and FIR output bus between the tap multiplier
// and the tap accumulator.
interface fir_tap_accumulator_if;
  logic        iMulValid;
  logic [15:0] iMulOut;
  logic [3:0]  iInSel;
  logic        iClrErr;
  logic [15:0] oFirOut;
  logic        oOutValid;
  logic        oBusy;
  logic        oSeqErr;

  modport master (
    output iMulValid, iMulOut, iInSel, iClrErr,
    input  oFirOut, oOutValid, oBusy, oSeqErr
  );

  modport slave (
    input  iMulValid, iMulOut, iInSel, iClrErr,
    output oFirOut, oOutValid, oBusy, oSeqErr
  );
endinterface

// File: rtl/fir_tap_accumulator.sv
// Sums NUM_TAPS signed tap products per frame into a wide accumulator and
// emits one saturated 16-bit FIR sample per frame; flags tap-order violations.
module fir_tap_accumulator #(
  parameter int unsigned NUM_TAPS = 10,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                 iClk_12M,
  input  logic                 iRst,
  fir_tap_accumulator_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_TAPS - 1);

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic [3:0]              expected;
  logic [15:0]             sat;

  assign prod_ext = {{(ACC_W-16){bus.iMulOut[15]}}, bus.iMulOut};
  assign sum      = acc + prod_ext;
  assign bus.oBusy = (state == ACCUM);

  // Bits above bit 15 must all match the sign bit for the sum to fit in 16 bits.
  always_comb begin
    sat = sum[15:0];
    if (!sum[ACC_W-1] && (|sum[ACC_W-2:15]))
      sat = 16'h7FFF;
    else if (sum[ACC_W-1] && !(&sum[ACC_W-2:15]))
      sat = 16'h8000;
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state         <= IDLE;
      acc           <= '0;
      expected      <= '0;
      bus.oFirOut   <= '0;
      bus.oOutValid <= 1'b0;
      bus.oSeqErr   <= 1'b0;
    end else begin
      bus.oOutValid <= 1'b0;
      if (bus.iClrErr)
        bus.oSeqErr <= 1'b0;
      // Violations below assign oSeqErr later, so a simultaneous clear loses.
      if (bus.iMulValid) begin
        case (state)
          IDLE: begin
            if (bus.iInSel == 4'd0) begin
              acc      <= prod_ext;
              expected <= 4'd1;
              state    <= ACCUM;
            end else begin
              bus.oSeqErr <= 1'b1;
            end
          end
          ACCUM: begin
            if (bus.iInSel == expected) begin
              if (expected == LAST_IDX) begin
                bus.oFirOut   <= sat;
                bus.oOutValid <= 1'b1;
                acc           <= '0;
                expected      <= '0;
                state         <= IDLE;
              end else begin
                acc      <= sum;
                expected <= expected + 4'd1;
              end
            end else if (bus.iInSel == 4'd0) begin
              bus.oSeqErr <= 1'b1;
              acc         <= prod_ext;
              expected    <= 4'd1;
            end else begin
              bus.oSeqErr <= 1'b1;
              acc         <= '0;
              expected    <= '0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Self-checking bench for fir_tap_accumulator: table-driven frames, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_fir_tap_accumulator;

  localparam int NUM_TAPS = 10;

  logic iClk_12M;
  logic iRst;
  fir_tap_accumulator_if bus();

  fir_tap_accumulator #(.NUM_TAPS(NUM_TAPS), .ACC_W(20)) dut (
    .iClk_12M (iClk_12M),
    .iRst     (iRst),
    .bus      (bus.slave)
  );

  initial iClk_12M = 1'b0;
  always #5 iClk_12M = ~iClk_12M;

  int checks   = 0;
  int failures = 0;

  // Reference model: the open frame is simply the list of products received.
  int          frame_q[$];
  logic [15:0] m_out;
  logic        m_valid;
  logic        m_err;

  typedef struct {
    logic [15:0] lo;       // value for taps 0..4
    logic [15:0] hi;       // value for taps 5..9
    logic [15:0] exp_out;
  } frame_vec_t;

  frame_vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  task automatic model_reset();
    frame_q.delete();
    m_out   = 16'h0000;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic [3:0] sel,
                            input logic clr);
    int val;
    int s;
    val     = int'($signed(d));
    m_valid = 1'b0;
    if (clr) m_err = 1'b0;
    if (v) begin
      if (frame_q.size() == 0) begin
        if (sel == 4'd0) frame_q.push_back(val);
        else m_err = 1'b1;
      end else if (int'(sel) == frame_q.size()) begin
        frame_q.push_back(val);
        if (frame_q.size() == NUM_TAPS) begin
          s = 0;
          foreach (frame_q[i]) s += frame_q[i];
          m_out   = sat16(s);
          m_valid = 1'b1;
          frame_q.delete();
        end
      end else if (sel == 4'd0) begin
        m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(val);
      end else begin
        m_err = 1'b1;
        frame_q.delete();
      end
    end
  endtask

  // Entered and left at posedge+1: drive, clock, then compare against the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] sel,
                       input logic clr);
    bus.iMulValid = v;
    bus.iMulOut   = d;
    bus.iInSel    = sel;
    bus.iClrErr   = clr;
    model_step(v, d, sel, clr);
    @(posedge iClk_12M);
    #1;
    chk("fir_out", 32'(bus.oFirOut), 32'(m_out));
    chk("out_valid", 32'(bus.oOutValid), 32'(m_valid));
    chk("busy", 32'(bus.oBusy), 32'(frame_q.size() != 0));
    chk("seq_err", 32'(bus.oSeqErr), 32'(m_err));
    bus.iMulValid = 1'b0;
    bus.iClrErr   = 1'b0;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 16'h0000, 4'd0, 1'b0);
  endtask

  task automatic feed_frame(input logic [15:0] lo, input logic [15:0] hi);
    for (int t = 0; t < NUM_TAPS; t++)
      cycle(1'b1, (t < 5) ? lo : hi, 4'(t), 1'b0);
  endtask

  task automatic async_reset_check();
    #2;
    iRst = 1'b1;
    #1;
    chk("arst_fir", 32'(bus.oFirOut), 32'h0);
    chk("arst_valid", 32'(bus.oOutValid), 32'h0);
    chk("arst_busy", 32'(bus.oBusy), 32'h0);
    chk("arst_err", 32'(bus.oSeqErr), 32'h0);
    model_reset();
    @(negedge iClk_12M);
    iRst = 1'b0;
    @(posedge iClk_12M);
    #1;
  endtask

  initial begin
    vecs[0] = '{lo: 16'h0001, hi: 16'h0001, exp_out: 16'd10};
    vecs[1] = '{lo: 16'h7FFF, hi: 16'h7FFF, exp_out: 16'h7FFF};
    vecs[2] = '{lo: 16'h8000, hi: 16'h8000, exp_out: 16'h8000};
    vecs[3] = '{lo: 16'h7FFF, hi: 16'h8001, exp_out: 16'h0000};
    vecs[4] = '{lo: 16'hFFFF, hi: 16'hFFFF, exp_out: 16'hFFF6};
    vecs[5] = '{lo: 16'd1000, hi: 16'd2000, exp_out: 16'd15000};
    vecs[6] = '{lo: 16'h7000, hi: 16'h0000, exp_out: 16'h7FFF};

    bus.iMulValid = 1'b0;
    bus.iMulOut   = '0;
    bus.iInSel    = '0;
    bus.iClrErr   = 1'b0;
    iRst = 1'b1;
    model_reset();
    @(posedge iClk_12M);
    #1;
    chk("rst_fir", 32'(bus.oFirOut), 32'h0);
    chk("rst_valid", 32'(bus.oOutValid), 32'h0);
    chk("rst_busy", 32'(bus.oBusy), 32'h0);
    chk("rst_err", 32'(bus.oSeqErr), 32'h0);
    iRst = 1'b0;
    idle_cycle();

    // Reset mid-frame discards the partial sum.
    for (int t = 0; t < 5; t++) cycle(1'b1, 16'd100, 4'(t), 1'b0);
    async_reset_check();
    feed_frame(16'd1, 16'd1);
    chk("post_rst_sum", 32'(bus.oFirOut), 32'd10);

    // Normal frame 1..10.
    idle_cycle();
    for (int t = 0; t < NUM_TAPS; t++) cycle(1'b1, 16'(t + 1), 4'(t), 1'b0);
    chk("normal_sum", 32'(bus.oFirOut), 32'd55);
    chk("normal_strobe", 32'(bus.oOutValid), 32'd1);
    idle_cycle();
    chk("normal_strobe_1cyc", 32'(bus.oOutValid), 32'd0);
    chk("normal_busy_low", 32'(bus.oBusy), 32'd0);
    chk("normal_hold", 32'(bus.oFirOut), 32'd55);

    // Table of whole frames including saturation boundaries.
    foreach (vecs[i]) begin
      feed_frame(vecs[i].lo, vecs[i].hi);
      chk("table_sum", 32'(bus.oFirOut), 32'(vecs[i].exp_out));
      chk("table_strobe", 32'(bus.oOutValid), 32'd1);
      idle_cycle();
    end

    // Sequence error: 0,1,2 then 5.
    for (int t = 0; t < 3; t++) cycle(1'b1, 16'd7, 4'(t), 1'b0);
    cycle(1'b1, 16'd7, 4'd5, 1'b0);
    chk("seqerr_flag", 32'(bus.oSeqErr), 32'd1);
    chk("seqerr_idle", 32'(bus.oBusy), 32'd0);
    chk("seqerr_nostrobe", 32'(bus.oOutValid), 32'd0);
    feed_frame(16'd3, 16'd4);
    chk("seqerr_next_sum", 32'(bus.oFirOut), 32'd35);
    chk("seqerr_sticky", 32'(bus.oSeqErr), 32'd1);
    cycle(1'b0, 16'h0000, 4'd0, 1'b1);
    chk("seqerr_cleared", 32'(bus.oSeqErr), 32'd0);
    // Violation and clear in the same cycle: set wins.
    cycle(1'b1, 16'd9, 4'd3, 1'b1);
    chk("set_wins", 32'(bus.oSeqErr), 32'd1);
    cycle(1'b0, 16'h0000, 4'd0, 1'b1);

    // Premature restart.
    for (int t = 0; t < 4; t++) cycle(1'b1, 16'd50, 4'(t), 1'b0);
    feed_frame(16'd1, 16'd1);
    chk("restart_sum", 32'(bus.oFirOut), 32'd10);
    chk("restart_err", 32'(bus.oSeqErr), 32'd1);
    cycle(1'b0, 16'h0000, 4'd0, 1'b1);

    // Randomized frames with gaps, back-to-back starts and occasional bad indices.
    for (int f = 0; f < 40; f++) begin
      for (int t = 0; t < NUM_TAPS; t++) begin
        int gaps;
        logic [3:0] sel;
        gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int g = 0; g < gaps; g++) idle_cycle();
        sel = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'(t);
        cycle(1'b1, 16'($urandom), sel, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
